// File: rtl/reg_pipe.sv
// reg_pipe: WIDTH-bit input-capture pipeline of DEPTH stages with per-stage valid,
// run-time PASS/HOLD/FLUSH/XACC modes, and a saturating out_data change counter.
// Define REG_PIPE_PARITY_EN to get a registered even-parity output.
module reg_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [7:0]       chg_cnt,
  output logic             out_parity
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_FLUSH = 2'b10,
    MODE_XACC  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic [7:0]       cnt_q;

  logic             shift;
  logic [WIDTH-1:0] head_data;
  logic             head_valid;
  logic [WIDTH-1:0] next_out;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    shift      = 1'b0;
    head_data  = RESET_VAL;
    head_valid = 1'b0;
    unique case (mode_e'(mode))
      MODE_PASS: begin
        shift      = 1'b1;
        head_data  = in_valid ? in_data : RESET_VAL;
        head_valid = in_valid;
      end
      MODE_HOLD:  shift = 1'b0;
      MODE_FLUSH: shift = 1'b1;
      MODE_XACC: begin
        shift      = 1'b1;
        head_data  = data_q[0] ^ (in_valid ? in_data : '0);
        head_valid = valid_q[0] | in_valid;
      end
    endcase
  end

  // Value the last stage will take on a shifting edge.
  if (DEPTH == 1) begin : g_single
    assign next_out = head_data;
  end else begin : g_multi
    assign next_out = data_q[DEPTH-2];
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the old values.
  // NOTE: the stage array is reset explicitly because bubbles must read back as RESET_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k]  <= RESET_VAL;
        valid_q[k] <= 1'b0;
      end
    end else if (ena && shift) begin
      data_q[0]  <= head_data;
      valid_q[0] <= head_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // clr_cnt bypasses ena and beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_q <= '0;
    end else if (ena && shift && (next_out != data_q[DEPTH-1]) && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

`ifdef REG_PIPE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= ^RESET_VAL;
    end else if (ena && shift) begin
      parity_q <= ^next_out;
    end
  end

  assign out_parity = parity_q;
`else
  assign out_parity = 1'b0;
`endif

  assign out_data  = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign chg_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: DEPTH=3 and DEPTH=1 instances share stimulus; a queue-based
// model is compared every cycle, plus hand-computed literal expectations.
module tb_reg_pipe;

  logic       clk = 1'b0;
  logic       rst, ena, in_valid, clr_cnt;
  logic [1:0] mode;
  logic [7:0] in_data;

  logic [7:0] o3_data, o1_data, c3_dut, c1_dut;
  logic       o3_valid, o1_valid, p3_dut, p1_dut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_d3 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .clr_cnt(clr_cnt), .out_data(o3_data),
    .out_valid(o3_valid), .chg_cnt(c3_dut), .out_parity(p3_dut)
  );

  reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .clr_cnt(clr_cnt), .out_data(o1_data),
    .out_valid(o1_valid), .chg_cnt(c1_dut), .out_parity(p1_dut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each pipeline is a queue of {data,valid}; index 0 is the input side.
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } stage_t;

  stage_t     m3[$];
  stage_t     m1[$];
  logic [7:0] c3, c1;
  bit         live = 1'b0;

  function automatic stage_t new_head(input stage_t cur);
    stage_t h;
    case (mode)
      2'b00: begin
        h.data  = in_valid ? in_data : 8'h00;
        h.valid = in_valid;
      end
      2'b10: begin
        h.data  = 8'h00;
        h.valid = 1'b0;
      end
      default: begin
        h.data  = cur.data ^ (in_valid ? in_data : 8'h00);
        h.valid = cur.valid | in_valid;
      end
    endcase
    return h;
  endfunction

  function automatic logic [7:0] bump(input logic [7:0] c, input bit changed);
    return (changed && c != 8'd255) ? c + 8'd1 : c;
  endfunction

  function automatic logic exp_parity(input logic [7:0] d);
`ifdef REG_PIPE_PARITY_EN
    return ^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic model_step();
    stage_t h, old;
    if (rst) begin
      m3 = {};
      m1 = {};
      for (int i = 0; i < 3; i++) m3.push_back(9'h000);
      m1.push_back(9'h000);
      c3 = 8'd0;
      c1 = 8'd0;
      live = 1'b1;
    end else if (live) begin
      if (ena && mode != 2'b01) begin
        old = m3[$];
        h = new_head(m3[0]);
        m3.push_front(h);
        void'(m3.pop_back());
        c3 = bump(c3, m3[$].data != old.data);
        old = m1[$];
        h = new_head(m1[0]);
        m1.push_front(h);
        void'(m1.pop_back());
        c1 = bump(c1, m1[$].data != old.data);
      end
      if (clr_cnt) begin
        c3 = 8'd0;
        c1 = 8'd0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      check("d3_data",   o3_data,  m3[$].data);
      check("d3_valid",  o3_valid, m3[$].valid);
      check("d3_cnt",    c3_dut,   c3);
      check("d3_parity", p3_dut,   exp_parity(m3[$].data));
      check("d1_data",   o1_data,  m1[$].data);
      check("d1_valid",  o1_valid, m1[$].valid);
      check("d1_cnt",    c1_dut,   c1);
      check("d1_parity", p1_dut,   exp_parity(m1[$].data));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; mode = 2'b00; in_data = 8'hFF; in_valid = 1'b1; clr_cnt = 1'b0;
    tick(2);
    check("rst_d3_data", o3_data, 8'h00);
    check("rst_d3_valid", o3_valid, 1'b0);
    check("rst_d3_cnt", c3_dut, 8'd0);
    check("rst_d1_valid", o1_valid, 1'b0);

    // PASS latency: single A5 sample
    rst = 1'b0; in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_data = 8'h00; in_valid = 1'b0;
    check("lat_d1_data", o1_data, 8'hA5);
    check("lat_d3_early", o3_valid, 1'b0);
    tick(2);
    check("lat_d3_data", o3_data, 8'hA5);
    check("lat_d3_valid", o3_valid, 1'b1);
    tick();
    check("lat_d3_after", {o3_data, o3_valid}, 9'h000);
    check("lat_d3_cnt", c3_dut, 8'd2);

    // HOLD: 01,02,03 then 4 hold cycles
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      tick();
    end
    check("hold_first", o3_data, 8'h01);
    mode = 2'b01; in_valid = 1'b0; in_data = 8'h00;
    tick(4);
    check("hold_frozen", o3_data, 8'h01);
    mode = 2'b00;
    tick();
    check("hold_second", o3_data, 8'h02);
    tick();
    check("hold_third", o3_data, 8'h03);
    tick();
    check("hold_drained", {o3_data, o3_valid}, 9'h000);

    // XACC on a fresh pipeline
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'b11; in_valid = 1'b1;
    in_data = 8'h0F; tick();
    check("xacc_0f", {o1_data, o1_valid}, {8'h0F, 1'b1});
    in_data = 8'hF0; tick();
    check("xacc_ff", {o1_data, o1_valid}, {8'hFF, 1'b1});
    in_data = 8'hFF; tick();
    check("xacc_00", {o1_data, o1_valid}, {8'h00, 1'b1});

    // FLUSH empties DEPTH=3 in 3 edges
    mode = 2'b10; in_valid = 1'b0;
    tick();
    check("flush_d1", {o1_data, o1_valid}, 9'h000);
    tick(2);
    check("flush_d3", {o3_data, o3_valid}, 9'h000);

    // Counter saturation then clear on a changing edge
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2 == 0) ? 8'h55 : 8'hAA;
      tick();
    end
    check("sat_d1", c1_dut, 8'd255);
    check("sat_d3", c3_dut, 8'd255);
    in_data = 8'h55; clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_d1", c1_dut, 8'd0);
    check("clr_d3", c3_dut, 8'd0);

    // ena low freezes stages; clr_cnt still acts
    in_data = 8'hAA; tick();
    in_data = 8'h55; tick();
    check("cnt_regrow", c1_dut, 8'd2);
    ena = 1'b0; in_data = 8'h3C;
    tick(2);
    check("ena_frozen", o1_data, 8'h55);
    check("ena_cnt", c1_dut, 8'd2);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("ena_clr", c1_dut, 8'd0);
    ena = 1'b1;

    // Parity
    in_data = 8'h07; tick();
`ifdef REG_PIPE_PARITY_EN
    check("par_07", p1_dut, 1'b1);
`else
    check("par_07", p1_dut, 1'b0);
`endif
    in_data = 8'h03; tick();
    check("par_03", p1_dut, 1'b0);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
